// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch/jump resolution, next-PC select and architectural PC register
// Optional macro BRANCH_STATS_EN adds saturating BrCount/TakenCount outputs.
module branch_pc_unit #(
   parameter int unsigned  N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = 'h0,
   parameter logic [N-1:0] TRAP_VECTOR  = 'h100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         En,
   input  logic         Eq,
   input  logic         Lt,
   input  logic         Ltu,
   input  logic         Branch,
   input  logic         Jal,
   input  logic         Jalr,
   input  logic [2:0]   Funct3,
   input  logic [N-1:0] Imm,
   input  logic [N-1:0] Rs1,
   output logic [N-1:0] PC,
   output logic [N-1:0] PC_Plus4,
   output logic         Taken,
   output logic         Misaligned,
   output logic         Illegal
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]  BrCount,
   output logic [31:0]  TakenCount
`endif
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_TRAP} state_t;

   localparam logic [N-1:0] ALIGN_MASK = ~N'(1);

   state_t       state, state_nxt;
   logic [N-1:0] pc_nxt;
   logic [N-1:0] target;
   logic         cond;
   logic         redirect;
   logic         trap;
   logic         mis_nxt;

   assign PC_Plus4 = PC + N'(4);

   always_comb begin
      cond = 1'b0;
      case (Funct3)
         3'b000:  cond = Eq;
         3'b001:  cond = !Eq;
         3'b100:  cond = Lt;
         3'b101:  cond = !Lt;
         3'b110:  cond = Ltu;
         3'b111:  cond = !Ltu;
         default: cond = 1'b0;
      endcase

      // Jal outranks Jalr, which outranks Branch, when controls collide
      if (Jal)
         target = PC + Imm;
      else if (Jalr)
         target = (Rs1 + Imm) & ALIGN_MASK;
      else
         target = PC + Imm;

      redirect = Jal | Jalr | (Branch & cond);
      Illegal  = (Branch && (Funct3[2:1] == 2'b01)) ||
                 (Jal && Jalr) || (Jal && Branch) || (Jalr && Branch);
      Taken    = (state == S_RUN) && redirect;
      trap     = Taken && target[1];

      state_nxt = state;
      pc_nxt    = PC;
      mis_nxt   = 1'b0;
      case (state)
         S_BOOT: state_nxt = S_RUN;
         S_RUN: begin
            if (trap) begin
               pc_nxt    = TRAP_VECTOR;
               state_nxt = S_TRAP;
               mis_nxt   = 1'b1;
            end else begin
               pc_nxt = Taken ? target : PC_Plus4;
            end
         end
         S_TRAP: state_nxt = S_RUN;
         default: state_nxt = S_BOOT;
      endcase
   end

   // Misaligned is only ever set for one edge, so it drops even while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         PC         <= RESET_VECTOR;
         state      <= S_BOOT;
         Misaligned <= 1'b0;
      end else begin
         Misaligned <= En & mis_nxt;
         if (En) begin
            PC    <= pc_nxt;
            state <= state_nxt;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   logic count_en;

   assign count_en = En && (state == S_RUN) && Branch && !Illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         BrCount    <= '0;
         TakenCount <= '0;
      end else if (count_en) begin
         if (BrCount != 32'hFFFFFFFF)
            BrCount <= BrCount + 32'd1;
         if (Taken && (TakenCount != 32'hFFFFFFFF))
            TakenCount <= TakenCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit
// Expected PC/Misaligned are queued at drive time and popped after each edge.
module tb_branch_pc_unit;

   logic        clk = 1'b0;
   logic        rst, En, Eq, Lt, Ltu, Branch, Jal, Jalr;
   logic [2:0]  Funct3;
   logic [31:0] Imm, Rs1;
   logic [31:0] PC, PC_Plus4;
   logic        Taken, Misaligned, Illegal;
`ifdef BRANCH_STATS_EN
   logic [31:0] BrCount, TakenCount;
   logic [31:0] m_br, m_tk;
`endif

   int total = 0;
   int bad   = 0;

   logic [32:0] exp_q[$];
   logic [31:0] m_pc;
   int          m_state;   // 0 boot, 1 run, 2 trap
   logic        m_mis;

   branch_pc_unit dut (
      .clk(clk), .rst(rst), .En(En), .Eq(Eq), .Lt(Lt), .Ltu(Ltu),
      .Branch(Branch), .Jal(Jal), .Jalr(Jalr), .Funct3(Funct3),
      .Imm(Imm), .Rs1(Rs1), .PC(PC), .PC_Plus4(PC_Plus4),
      .Taken(Taken), .Misaligned(Misaligned), .Illegal(Illegal)
`ifdef BRANCH_STATS_EN
      , .BrCount(BrCount), .TakenCount(TakenCount)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One cycle: drive at negedge, check combinational outputs, queue and check registered ones
   task automatic cyc(input logic r, input logic en, input logic eq, input logic lt,
                      input logic ltu, input logic br, input logic jal, input logic jalr,
                      input logic [2:0] f3, input logic [31:0] imm, input logic [31:0] rs1);
      logic        m_taken, m_ill, c;
      logic [31:0] tgt, npc;
      logic [32:0] e;
      int          nstate;
      rst = r; En = en; Eq = eq; Lt = lt; Ltu = ltu; Branch = br; Jal = jal; Jalr = jalr;
      Funct3 = f3; Imm = imm; Rs1 = rs1;
      #1;
      case (f3)
         3'd0: c = eq;   3'd1: c = !eq;
         3'd4: c = lt;   3'd5: c = !lt;
         3'd6: c = ltu;  3'd7: c = !ltu;
         default: c = 1'b0;
      endcase
      m_taken = (m_state == 1) && (jal || jalr || (br && c));
      m_ill   = (br && (f3 == 3'd2 || f3 == 3'd3)) || ((int'(br) + int'(jal) + int'(jalr)) > 1);
      if (jal)       tgt = m_pc + imm;
      else if (jalr) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      else           tgt = m_pc + imm;
      check("taken", {31'd0, Taken}, {31'd0, m_taken});
      check("illegal", {31'd0, Illegal}, {31'd0, m_ill});
      check("plus4", PC_Plus4, m_pc + 32'd4);
`ifdef BRANCH_STATS_EN
      if (!r && en && m_state == 1 && br && !m_ill) begin
         if (m_br != 32'hFFFFFFFF) m_br++;
         if (m_taken && m_tk != 32'hFFFFFFFF) m_tk++;
      end
      if (r) begin m_br = 0; m_tk = 0; end
`endif
      npc = m_pc; nstate = m_state;
      if (r) begin
         npc = 32'h0; nstate = 0; m_mis = 1'b0;
      end else begin
         m_mis = 1'b0;
         if (en) begin
            if (m_state == 1) begin
               if (m_taken && tgt[1]) begin
                  npc = 32'h100; nstate = 2; m_mis = 1'b1;
               end else begin
                  npc = m_taken ? tgt : m_pc + 32'd4;
               end
            end else begin
               nstate = 1;
            end
         end
      end
      exp_q.push_back({npc, m_mis});
      m_pc = npc; m_state = nstate;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check("pc", PC, e[32:1]);
      check("mis", {31'd0, Misaligned}, {31'd0, e[0]});
`ifdef BRANCH_STATS_EN
      check("brcount", BrCount, m_br);
      check("takencount", TakenCount, m_tk);
`endif
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   initial begin
      m_pc = 32'h0; m_state = 0; m_mis = 1'b0;
`ifdef BRANCH_STATS_EN
      m_br = 0; m_tk = 0;
`endif
      @(negedge clk);
      // reset, then the boot cycle holds PC=0 and suppresses a JAL
      do_reset(2);
      check("reset_pc", PC, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h40, 32'd0);
      check("boot_hold", PC, 32'h0);
      idle(3);
      check("pc_12", PC, 32'hC);
      idle(1);
      // BEQ taken then not taken
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'd0);
      check("beq_taken", PC, 32'h30);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h20, 32'd0);
      check("beq_not", PC, 32'h34);
      idle(3);
      // BNE and BGEU with a negative offset
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'hFFFF_FFF0, 32'd0);
      check("bne_neg", PC, 32'h30);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFF0, 32'd0);
      check("bgeu_not", PC, 32'h34);
      // misaligned JALR traps, TRAP holds once, then resumes
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'h1003);
      check("trap_pc", PC, 32'h100);
      check("trap_mis", {31'd0, Misaligned}, 32'd1);
      idle(1);
      check("trap_hold", PC, 32'h100);
      idle(1);
      check("trap_exit", PC, 32'h104);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'h1001);
      check("jalr_ok", PC, 32'h1000);
      // stall with JAL pending
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h8, 32'd0);
      check("stall", PC, 32'h1000);
      // JAL + Branch collide: JAL wins, Illegal flagged
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'd0);
      check("collide", PC, 32'h1040);
      // illegal branch funct3 is not taken
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'd0);
      // trap, then a stalled cycle still clears Misaligned
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h2, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      check("stall_mis", {31'd0, Misaligned}, 32'd0);
      // reset in the middle of TRAP
      do_reset(1);
      check("rst_trap", PC, 32'h0);
      idle(2);
      // randomized RUN traffic
      for (int i = 0; i < 60; i++)
         cyc(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
             3'($urandom), {$urandom_range(0, 63), 2'b00} + 32'($urandom_range(0, 1) * 2),
             32'($urandom));
`ifdef BRANCH_STATS_EN
      do_reset(1);
      idle(1);
      for (int i = 0; i < 5; i++)
         cyc(1'b0, 1'b1, (i % 2 == 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h8, 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'h8, 32'd0);
      check("br5", BrCount, 32'd5);
      check("tk3", TakenCount, 32'd3);
      dut.BrCount = 32'hFFFF_FFFE;
      dut.TakenCount = 32'hFFFF_FFFE;
      m_br = 32'hFFFF_FFFE; m_tk = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h8, 32'd0);
      check("br_sat", BrCount, 32'hFFFF_FFFF);
      check("tk_sat", TakenCount, 32'hFFFF_FFFF);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Downstream consumer of the N-bit equality comparator in the single-cycle RISC-V core.
- Takes the comparator's Eq result, plus the less-than flags, together with decoded branch and jump controls.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, computes the next PC and holds the architectural PC register.
- Sequences boot and misaligned-target traps with a small FSM.

Parameters:
- N, 32, datapath and PC width.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- TRAP_VECTOR, 32'h00000100, PC loaded on a misaligned control-transfer target.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  reset.
- En  input  1  PC advance enable; 0 = stall, hold PC and FSM.
- Eq  input  1  equality result from comparator (Data0 == Data1).
- Lt  input  1  signed rs1 < rs2.
- Ltu  input  1  unsigned rs1 < rs2.
- Branch  input  1  conditional branch instruction.
- Jal  input  1  JAL instruction.
- Jalr  input  1  JALR instruction.
- Funct3  input  3  branch condition select.
- Imm  input  N  sign-extended immediate.
- Rs1  input  N  rs1 value (JALR base).
- PC  output  N  current instruction address (registered).
- PC_Plus4  output  N  PC+4, combinational (link value).
- Taken  output  1  combinational: current instruction redirects the PC.
- Misaligned  output  1  registered one-cycle pulse: a trap was taken.
- Illegal  output  1  combinational: Funct3 010/011 with Branch, or more than one of Branch/Jal/Jalr asserted.

Behaviour:
- Reset: one clock clk; reset rst is synchronous and active-high. While rst is high at a clock edge: PC=RESET_VECTOR, Misaligned=0, FSM=BOOT. rst has priority over En.
- FSM states:
  - BOOT: PC held at RESET_VECTOR for exactly one enabled cycle; Taken forced 0. Next state is RUN.
  - RUN: normal operation.
  - TRAP: entered when the computed target is misaligned. The edge that enters TRAP loads PC=TRAP_VECTOR and sets Misaligned=1. While in TRAP, Taken=0 and PC holds for one enabled cycle, then RUN. Misaligned clears on the first edge after it was set, regardless of En.
- Condition decode when Branch=1:
  - 000 BEQ: Eq.
  - 001 BNE: !Eq.
  - 100 BLT: Lt.
  - 101 BGE: !Lt.
  - 110 BLTU: Ltu.
  - 111 BGEU: !Ltu.
  - 010/011: not taken, Illegal=1.
- Priority: Jal > Jalr > Branch. If more than one is asserted, Illegal=1 and the highest-priority control is executed.
- Targets, mod 2^N, wrap-around silently:
  - JAL/branch target = PC+Imm.
  - JALR target = (Rs1+Imm) with bit0 cleared.
- Next PC = target if Taken, else PC+4.
- Misaligned check: applies only when Taken=1 and target[1]!=0; not-taken is never checked. The trap replaces the target load.
- En=0: PC, FSM and Misaligned hold; Misaligned still self-clears. Combinational outputs keep tracking inputs.
- Latency: PC updates on the edge following the decision; no bubbles in RUN.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs BrCount[31:0] and TakenCount[31:0].
  - Both reset to 0 under rst.
  - On each enabled RUN cycle with Branch=1 and no Illegal, BrCount increments.
  - TakenCount additionally increments if Taken=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset and boot: rst=1 for 2 cycles, then En=1 with no controls. PC=0 during reset and the BOOT cycle, then 4, 8, 12; Misaligned=0 throughout.
- BEQ taken/not-taken: PC=32'h10, Branch=1, Funct3=000, Imm=32'h20.
  - Eq=1: Taken=1, next PC=32'h30.
  - Eq=0 at PC=32'h30: Taken=0, next PC=32'h34.
- BNE/BGEU with negative offset: PC=32'h40, Imm=32'hFFFFFFF0.
  - Funct3=001, Eq=0: PC becomes 32'h30.
  - Funct3=111, Ltu=1: not taken, PC becomes 32'h34.
- JALR alignment: Rs1=32'h1003, Imm=0, Jalr=1. Target 32'h1002 is misaligned, so PC=TRAP_VECTOR, Misaligned=1 for one cycle, then TRAP hold, then PC+4.
  - Repeat with Rs1=32'h1001: target 32'h1000, no trap.
- Stall and simultaneous: En=0 with Jal=1 for 3 cycles leaves PC unchanged. Jal=1 and Branch=1 with Eq=1: Illegal=1 and the JAL target is used.
  - Assert rst mid-TRAP: PC=RESET_VECTOR, Misaligned=0 on the next edge.
- BRANCH_STATS_EN: 5 branches with 3 taken give BrCount=5, TakenCount=3. Funct3=010 does not count. Preloading the counters near 32'hFFFFFFFF shows saturation.
